// File: rtl/result_batcher_pkg.sv
// result_batcher_pkg: shared types and widths for the result batcher.
package result_batcher_pkg;
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;
  localparam int DW_DEF = 8;
  function automatic int sum_w(input int dw, input int batch);
    return dw + $clog2(batch);
  endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with full/empty flags; overflowing pushes and underflowing pops are ignored.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/result_batcher.sv
// result_batcher: buffers result pulses and emits per-batch sum/max on valid/ready.
// Define RESULT_BATCHER_MAX_EN to build the max tracker; otherwise out_max is tied to 0.
module result_batcher
  import result_batcher_pkg::*;
#(
  parameter int  BATCH      = 4,
  parameter int  DW         = DW_DEF,
  parameter int  FIFO_DEPTH = 4,
  localparam int SW         = sum_w(DW, BATCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [DW-1:0] out_max,
  output logic          drop_err
);
  localparam int CW = $clog2(BATCH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] head;
  logic full, empty, pop, accept, drop_q;
  result_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign in_ready  = !full;
  assign out_valid = state_q == HOLD;
  assign out_sum   = sum_q;
  assign drop_err  = drop_q;
  assign pop       = (state_q == COLLECT) && !empty;
  assign accept    = out_valid && out_ready;
  always_comb begin
    sum_d   = accept ? '0 : pop ? sum_q + SW'(head) : sum_q;
    cnt_d   = accept ? '0 : pop ? cnt_q + CW'(1) : cnt_q;
    state_d = accept ? COLLECT : (pop && cnt_q == CW'(BATCH - 1)) ? HOLD : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sum_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      drop_q  <= drop_q | (in_valid & full);
    end
  end
`ifdef RESULT_BATCHER_MAX_EN
  logic [DW-1:0] max_q, max_d;
  assign out_max = max_q;
  always_comb max_d = accept ? '0 : (pop && head > max_q) ? head : max_q;
  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else max_q <= max_d;
  end
`else
  assign out_max = '0;
`endif
endmodule

// File: tb/tb_result_batcher.sv
// tb_result_batcher: directed checks of batching, backpressure, overflow, width and reset.
module tb_result_batcher;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, drop_err;
  logic [7:0] in_data, out_max;
  logic [9:0] out_sum;
  int tests = 0;
  int fails = 0;
`ifdef RESULT_BATCHER_MAX_EN
  localparam bit MAX_ON = 1'b1;
`else
  localparam bit MAX_ON = 1'b0;
`endif

  result_batcher dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_max   (out_max),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step(1);
      n++;
    end
    check({tag, "_seen"}, 32'(out_valid), 32'd1);
  endtask

  function automatic logic [31:0] emax(input logic [31:0] m);
    return MAX_ON ? m : 32'd0;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_max", 32'(out_max), 32'd0);
    check("rst_drop", 32'(drop_err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    pulse(8'd10); step(2);
    pulse(8'd20); step(2);
    pulse(8'd30); step(2);
    pulse(8'd40);
    check("basic_early", 32'(out_valid), 32'd0);
    step(1);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_sum", 32'(out_sum), 32'd100);
    check("basic_max", 32'(out_max), emax(40));
    step(1);
    check("basic_one_cycle", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    pulse(8'd10); pulse(8'd20); pulse(8'd30); pulse(8'd40);
    pulse(8'd1); pulse(8'd2); pulse(8'd3); pulse(8'd4);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_sum", 32'(out_sum), 32'd100);
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_no_drop_yet", 32'(drop_err), 32'd0);
    pulse(8'd99);
    check("bp_drop", 32'(drop_err), 32'd1);
    step(3);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_sum", 32'(out_sum), 32'd100);
    out_ready = 1'b1;
    step(1);
    check("bp_accept", 32'(out_valid), 32'd0);
    wait_valid("bp2");
    check("bp2_sum", 32'(out_sum), 32'd10);
    check("bp2_max", 32'(out_max), emax(4));
    step(6);
    check("bp_99_absent", 32'(out_valid), 32'd0);
    check("bp_empty", 32'(in_ready), 32'd1);
    check("bp_drop_sticky", 32'(drop_err), 32'd1);

    repeat (4) pulse(8'd225);
    wait_valid("wide");
    check("wide_sum", 32'(out_sum), 32'd900);
    check("wide_max", 32'(out_max), emax(225));
    step(1);

    pulse(8'd5); pulse(8'd6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_drop", 32'(drop_err), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    repeat (4) pulse(8'd1);
    wait_valid("mid");
    check("mid_sum", 32'(out_sum), 32'd4);
    check("mid_max", 32'(out_max), emax(1));
    step(6);
    check("mid_single", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/result_batcher.md
# result_batcher

Downstream consumer of the clock-domain-crossing result stream. It receives single-cycle result pulses (8-bit sum/product values) in the destination clock domain and buffers them in a small FIFO. It accumulates each group of BATCH results into a sum and a maximum, then presents the batch summary on a valid/ready handshake. Upstream has no backpressure, so overflow is detected and reported, never stalled.

## Interface
- BATCH, 4, results per batch; power of two, 2..16
- DW, 8, result width
- FIFO_DEPTH, 4, input buffer entries; power of two
- SW, DW+$clog2(BATCH), sum width (derived, not overridable)

- clk  in  1  sole clock (destination domain)
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  single-cycle result pulse
- in_data  in  DW  result value, sampled when in_valid=1
- in_ready  out  1  FIFO not full (informational; upstream ignores it)
- out_valid  out  1  batch summary valid
- out_ready  in  1  consumer accepts summary
- out_sum  out  SW  sum of the BATCH results
- out_max  out  DW  largest of the BATCH results (unsigned)
- drop_err  out  1  sticky; a result was lost to overflow

## Operation
- Reset values: out_valid=0, out_sum=0, out_max=0, drop_err=0, FIFO empty (in_ready=1), state=COLLECT, cnt=0.
- Push: in_valid && FIFO not full (occupancy at cycle start) → write in_data. in_valid while full → data discarded, drop_err←1 until rst.
- A push and a pop in the same cycle are both performed. A pop does not free space for a same-cycle push when full.
- FSM states:
  - COLLECT: if FIFO non-empty, pop head; sum←sum+head, max←max(max,head), cnt←cnt+1. If this pop is the BATCHth, go to HOLD at the same edge.
  - HOLD: out_valid=1, out_sum/out_max stable, no pops. Pushes continue into the FIFO. On out_valid&&out_ready, clear sum/max/cnt, go to COLLECT.
- Arithmetic: unsigned. SW bits cannot overflow (BATCH·(2^DW−1) < 2^SW). Compare is unsigned.
- out_sum/out_max are driven from the accumulator registers and hold their last values in COLLECT. They are meaningful only while out_valid=1.
- Reset mid-batch discards the partial batch and the FIFO contents.

## Timing
- No combinational path from in_* to out_*. in_ready depends on FIFO occupancy only.
- Push at edge t → earliest pop in cycle t+1 (no bypass).
- BATCHth pop in cycle c → out_valid=1 in cycle c+1.
- Minimum latency from the last push to out_valid is 2 cycles.
- The handshake completes at the edge where out_valid&&out_ready. out_valid=0 next cycle. A pop may occur in that next cycle.
- out_valid never drops without acceptance. out_sum/out_max never change while out_valid=1.
- Sustained throughput is one result per cycle plus a one-cycle handoff bubble per batch.

## Configuration
- RESULT_BATCHER_MAX_EN defined: the max tracker is built and out_max behaves as above.
- Not defined: max register and comparator are omitted, and out_max is tied to 0. All other behaviour and timing are unchanged.

## Structure
- Package result_batcher_pkg contains:
  - state enum (COLLECT, HOLD)
  - default DW
  - a function computing SW
- Sub-module result_fifo is a synchronous FIFO with full/empty flags and push/pop. It is parameterised by width and depth, with a synchronous active-high rst. It is instantiated once.

## Test plan
- Reset: rst=1 for 2 cycles → out_valid=0, out_sum=0, out_max=0, drop_err=0, in_ready=1.
- Basic batch: pulses 10,20,30,40 spaced 3 cycles, out_ready=1 → out_valid for exactly 1 cycle, 2 cycles after the 4th push, with out_sum=100 and out_max=40.
- Backpressure: out_ready=0; push 10,20,30,40 then 1,2,3,4.
  - out_valid is held with out_sum=100 steady.
  - FIFO fills and in_ready=0.
  - A 9th push of 99 → drop_err=1.
  - Raise out_ready → the second batch gives out_sum=10, out_max=4, and 99 is absent.
- Width boundary: four pulses of 225 → out_sum=900, out_max=225, and no wrap in 10 bits.
- Reset mid-batch: push 5,6, then rst for 1 cycle, then push 1,1,1,1 → a single batch with out_sum=4 and out_max=1.
- Macro off (RESULT_BATCHER_MAX_EN undefined): rerun the basic batch → out_sum=100, out_max=0.
